// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Operand/result handshake bundle for the sequential shift-add multiplier.
//
// Signals:
//   in_valid     operand pair valid (producer -> multiplier)
//   in_ready     multiplier idle and able to accept operands
//   A            WIDTH-bit multiplicand
//   B            WIDTH-bit multiplier
//   signed_mode  0 = unsigned, 1 = two's-complement, sampled with A/B
//   out_valid    product valid (multiplier -> consumer)
//   out_ready    consumer accepts the product
//   product      2*WIDTH-bit result
//   busy         high while the multiplier is iterating
//
// Modports:
//   master  the side that supplies operands and consumes products
//   slave   the multiplier itself
// ---------------------------------------------------------------------------
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, A, B, signed_mode, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, A, B, signed_mode, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier. Accepts one WIDTH x WIDTH operand pair per
// transaction, iterates once per operand bit and presents an exact 2*WIDTH
// product, unsigned or two's-complement signed, until the consumer takes it.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; aborts any operation in flight
//   bus   seq_multiplier_if slave modport carrying the in_valid/in_ready
//         operand handshake (A, B, signed_mode), the out_valid/out_ready
//         product handshake (product) and the busy status flag
//
// Timing: the accepting edge loads the operands, the next WIDTH edges each
// retire one multiplier bit, and one further edge applies the sign and
// writes the product, so out_valid rises WIDTH+1 edges after acceptance.
// ---------------------------------------------------------------------------
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   seq_multiplier_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } stateType;

   stateType             state;
   stateType             nextState;

   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   accum;
   logic [2*WIDTH-1:0]   productReg;
   logic [CW-1:0]        count;
   logic                 negFlag;

   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic [WIDTH:0]       partialSum;
   logic [2*WIDTH:0]     widePartial;
   logic [2*WIDTH-1:0]   accumStep;
   logic                 finalStep;

   // Operand magnitudes taken at acceptance. In signed mode a negative
   // operand is negated in WIDTH bits; the most negative value negates to
   // itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1),
   // so no extra bit is needed. The sign is restored once at the end.
   always_comb begin
      magA = bus.A;
      magB = bus.B;
      if (bus.signed_mode && bus.A[WIDTH-1]) begin
         magA = -bus.A;
      end
      if (bus.signed_mode && bus.B[WIDTH-1]) begin
         magB = -bus.B;
      end
   end

   // One shift-add iteration: conditionally add the multiplicand into the
   // upper half with a carry bit, then shift the carry and the whole
   // accumulator right by one. The lower half fills with finished product
   // bits while the upper half keeps the running partial sum.
   always_comb begin
      partialSum  = {1'b0, accum[2*WIDTH-1:WIDTH]};
      if (multiplier[0]) begin
         partialSum = partialSum + {1'b0, multiplicand};
      end
      widePartial = {partialSum, accum[WIDTH-1:0]};
      accumStep   = widePartial[2*WIDTH:1];
      finalStep   = (count == CW'(WIDTH));
   end

   // State register. Reset drops straight back to IDLE so an aborted
   // operation never reaches the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake outputs. in_ready, busy and out_valid are
   // pure functions of the state, so they change the instant reset hits.
   // Inputs other than out_ready are only looked at while IDLE.
   always_comb begin
      nextState     = state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      bus.product   = productReg;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               nextState = BUSY;
            end
         end
         BUSY: begin
            bus.busy = 1'b1;
            if (finalStep) begin
               nextState = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath. Acceptance loads magnitudes and the result sign and clears
   // the accumulator. Each BUSY cycle before the last retires one
   // multiplier bit; the last BUSY cycle writes the signed result into the
   // product register, which then holds until the next completion so the
   // consumer sees a stable value across backpressure and after handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         multiplicand <= '0;
         multiplier   <= '0;
         accum        <= '0;
         count        <= '0;
         negFlag      <= 1'b0;
         productReg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  multiplicand <= magA;
                  multiplier   <= magB;
                  negFlag      <= bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  accum        <= '0;
                  count        <= '0;
               end
            end
            BUSY: begin
               if (finalStep) begin
                  productReg <= negFlag ? -accum : accum;
               end else begin
                  accum      <= accumStep;
                  multiplier <= multiplier >> 1;
                  count      <= count + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier, the sequential successor to the team's 8-bit combinational multiplier. It accepts one WIDTH x WIDTH operand pair per transaction over a valid/ready handshake. It computes a 2*WIDTH product over WIDTH clock cycles, in unsigned or two's-complement signed mode. The product is held stable until the consumer accepts it. It sits in datapaths where a full array multiplier costs too much area.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block idle and able to accept operands
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with A/B
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result
busy  output  1  high while iterating

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal counter/accumulator=0. Reset asserted mid-computation aborts the operation immediately. No partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid=1, latch A, B and signed_mode.
  - Signed mode: store magnitudes |A|, |B| as WIDTH-bit unsigned values (the most-negative value -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) with no overflow). Store neg_flag = A[msb] XOR B[msb].
  - Unsigned mode: store operands unchanged, neg_flag=0.
  - Clear the accumulator, counter=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle: if multiplier LSB is 1, add multiplicand to the upper accumulator half with a (WIDTH+1)-bit carry. Shift {carry, accumulator} right by one; shift the multiplier right by one; counter++.
  - Exactly WIDTH iterations.
  - On the edge completing iteration WIDTH: product <= neg_flag ? two's-complement negation of the accumulator (2*WIDTH bits) : accumulator. Go to DONE.
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge. For WIDTH=8 that is edge 9 when the accept edge is edge 0.
- DONE:
  - out_valid=1, busy=0, in_ready=0, product held stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - out_ready may be held high in advance; the product is still presented for at least one cycle.
- Inputs in_valid, A, B and signed_mode are ignored outside IDLE.
- product retains its last value after the handshake until the next result is written.
- No overlap: a new operand pair is accepted no earlier than the cycle after the output handshake.
- Arithmetic: product is exact in both modes. No truncation or saturation is needed.
- Zero operands still take the full WIDTH iterations; there is no early exit.

Test Plan:
- WIDTH=8, unsigned, A=255, B=255, out_ready=1 -> product=16'hFE01 (65025); out_valid rises 9 edges after accept, high for exactly 1 cycle.
- WIDTH=8, signed: -128*-128 -> 16'h4000; -1*1 -> 16'hFFFF; -128*127 -> 16'hC080 (-16256); 0*-77 -> 16'h0000.
- Backpressure: unsigned 12*13 with out_ready=0 for 5 cycles after out_valid -> product=156 held stable and in_ready=0 throughout. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Ignored inputs: toggle A, B, signed_mode and in_valid during BUSY for 100*3 unsigned -> product=300 unaffected; no second transaction is started.
- Reset mid-op: assert rst at iteration 4 of 200*200 -> out_valid=0, in_ready=1 and product=0 immediately. A following 7*6 transaction yields 42 with normal latency.
- WIDTH=16 instance: unsigned 16'hFFFF*16'hFFFF -> 32'hFFFE0001 after 17 edges. Signed 16'h8000*16'h8000 -> 32'h40000000. Then 10 back-to-back random transactions in each mode checked against a reference A*B.
